// File: rtl/cgra_dma_pkg.sv
// Shared definitions for the CGRA DMA control/status register block.
// Contents: register byte offsets and word indices, CTRL/STATUS bit positions,
// AXI response codes, and a byte-strobe merge helper.
package cgra_dma_pkg;

   localparam int BYTES_PER_WORD  = 4;
   localparam int NUM_REGS        = 6;
   localparam int REG_SPACE_BYTES = NUM_REGS * BYTES_PER_WORD;

   localparam logic [7:0] OFF_CTRL   = 8'h00;
   localparam logic [7:0] OFF_STATUS = 8'h04;
   localparam logic [7:0] OFF_SRC    = 8'h08;
   localparam logic [7:0] OFF_DST    = 8'h0C;
   localparam logic [7:0] OFF_SIZE   = 8'h10;
   localparam logic [7:0] OFF_XCOUNT = 8'h14;

   localparam logic [2:0] IDX_CTRL   = 3'(OFF_CTRL   / BYTES_PER_WORD);
   localparam logic [2:0] IDX_STATUS = 3'(OFF_STATUS / BYTES_PER_WORD);
   localparam logic [2:0] IDX_SRC    = 3'(OFF_SRC    / BYTES_PER_WORD);
   localparam logic [2:0] IDX_DST    = 3'(OFF_DST    / BYTES_PER_WORD);
   localparam logic [2:0] IDX_SIZE   = 3'(OFF_SIZE   / BYTES_PER_WORD);
   localparam logic [2:0] IDX_XCOUNT = 3'(OFF_XCOUNT / BYTES_PER_WORD);

   localparam int CTRL_START_BIT  = 0;
   localparam int CTRL_IRQ_EN_BIT = 1;
   localparam int STATUS_BUSY_BIT = 0;
   localparam int STATUS_DONE_BIT = 1;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   // Replace only the bytes whose strobe is set.
   function automatic logic [31:0] merge_strb(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
      logic [31:0] res;
      res = old_val;
      for (int b = 0; b < BYTES_PER_WORD; b++) begin
         if (strb[b]) res[8*b +: 8] = new_val[8*b +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/cgra_axil_slave_if.sv
// AXI4-Lite slave front end: buffers AW and W independently (one entry each),
// presents one write commit per transaction, and registers the B and R
// responses.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   s_axi_*                  AXI4-Lite slave channels
//   wr_en/addr/data/strb     one-cycle write commit toward the register file
//   wr_err                   register file verdict for the commit (SLVERR)
//   rd_en/addr               one-cycle read request at the AR handshake
//   rd_data/rd_err           register file read value and verdict
module cgra_axil_slave_if
   import cgra_dma_pkg::*;
#(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 32
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
   input  logic                    s_axi_awvalid,
   output logic                    s_axi_awready,
   input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
   input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
   input  logic                    s_axi_wvalid,
   output logic                    s_axi_wready,
   output logic [1:0]              s_axi_bresp,
   output logic                    s_axi_bvalid,
   input  logic                    s_axi_bready,
   input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
   input  logic                    s_axi_arvalid,
   output logic                    s_axi_arready,
   output logic [DATA_WIDTH-1:0]   s_axi_rdata,
   output logic [1:0]              s_axi_rresp,
   output logic                    s_axi_rvalid,
   input  logic                    s_axi_rready,
   output logic                    wr_en,
   output logic [ADDR_WIDTH-1:0]   wr_addr,
   output logic [DATA_WIDTH-1:0]   wr_data,
   output logic [DATA_WIDTH/8-1:0] wr_strb,
   input  logic                    wr_err,
   output logic                    rd_en,
   output logic [ADDR_WIDTH-1:0]   rd_addr,
   input  logic [DATA_WIDTH-1:0]   rd_data,
   input  logic                    rd_err
);

   logic aw_held, w_held;

   // Readies are forced low while rst is held so nothing is accepted mid-reset.
   assign s_axi_awready = !rst && !aw_held && !s_axi_bvalid;
   assign s_axi_wready  = !rst && !w_held  && !s_axi_bvalid;
   assign s_axi_arready = !rst && !s_axi_rvalid;

   // Buffers stay full until the B handshake, so gating with bvalid keeps
   // the commit to a single cycle.
   assign wr_en   = aw_held && w_held && !s_axi_bvalid;
   assign rd_en   = s_axi_arvalid && s_axi_arready;
   assign rd_addr = s_axi_araddr;

   always_ff @(posedge clk) begin
      if (rst) begin
         aw_held      <= 1'b0;
         w_held       <= 1'b0;
         wr_addr      <= '0;
         wr_data      <= '0;
         wr_strb      <= '0;
         s_axi_bvalid <= 1'b0;
         s_axi_bresp  <= RESP_OKAY;
         s_axi_rvalid <= 1'b0;
         s_axi_rdata  <= '0;
         s_axi_rresp  <= RESP_OKAY;
      end else begin
         if (s_axi_awvalid && s_axi_awready) begin
            aw_held <= 1'b1;
            wr_addr <= s_axi_awaddr;
         end
         if (s_axi_wvalid && s_axi_wready) begin
            w_held  <= 1'b1;
            wr_data <= s_axi_wdata;
            wr_strb <= s_axi_wstrb;
         end
         if (wr_en) begin
            s_axi_bvalid <= 1'b1;
            s_axi_bresp  <= wr_err ? RESP_SLVERR : RESP_OKAY;
         end else if (s_axi_bvalid && s_axi_bready) begin
            s_axi_bvalid <= 1'b0;
            aw_held      <= 1'b0;
            w_held       <= 1'b0;
         end
         if (rd_en) begin
            s_axi_rvalid <= 1'b1;
            s_axi_rdata  <= rd_data;
            s_axi_rresp  <= rd_err ? RESP_SLVERR : RESP_OKAY;
         end else if (s_axi_rvalid && s_axi_rready) begin
            s_axi_rvalid <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/cgra_dma_csr.sv
// Register file that programs the CGRA DMA engine and reports its status.
// Registers: CTRL (START, IRQ_EN), STATUS (BUSY, sticky DONE), SRC, DST, SIZE,
// XCOUNT (completion counter).
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   s_axi_*                  AXI4-Lite slave channels
//   cfg_src/dst/size         transfer parameters to the engine
//   cfg_start                one-cycle start pulse to the engine
//   status_busy/done         engine busy level and completion pulse
//   irq                      level interrupt, DONE & IRQ_EN
module cgra_dma_csr
   import cgra_dma_pkg::*;
#(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 32
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
   input  logic                    s_axi_awvalid,
   output logic                    s_axi_awready,
   input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
   input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
   input  logic                    s_axi_wvalid,
   output logic                    s_axi_wready,
   output logic [1:0]              s_axi_bresp,
   output logic                    s_axi_bvalid,
   input  logic                    s_axi_bready,
   input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
   input  logic                    s_axi_arvalid,
   output logic                    s_axi_arready,
   output logic [DATA_WIDTH-1:0]   s_axi_rdata,
   output logic [1:0]              s_axi_rresp,
   output logic                    s_axi_rvalid,
   input  logic                    s_axi_rready,
   output logic [31:0]             cfg_src,
   output logic [31:0]             cfg_dst,
   output logic [31:0]             cfg_size,
   output logic                    cfg_start,
   input  logic                    status_busy,
   input  logic                    status_done,
   output logic                    irq
);

   logic                    wr_en, wr_err, rd_en, rd_err;
   logic [ADDR_WIDTH-1:0]   wr_addr, rd_addr;
   logic [DATA_WIDTH-1:0]   wr_data, rd_data;
   logic [DATA_WIDTH/8-1:0] wr_strb;

   cgra_axil_slave_if #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_axil (
      .clk           (clk),
      .rst           (rst),
      .s_axi_awaddr  (s_axi_awaddr),
      .s_axi_awvalid (s_axi_awvalid),
      .s_axi_awready (s_axi_awready),
      .s_axi_wdata   (s_axi_wdata),
      .s_axi_wstrb   (s_axi_wstrb),
      .s_axi_wvalid  (s_axi_wvalid),
      .s_axi_wready  (s_axi_wready),
      .s_axi_bresp   (s_axi_bresp),
      .s_axi_bvalid  (s_axi_bvalid),
      .s_axi_bready  (s_axi_bready),
      .s_axi_araddr  (s_axi_araddr),
      .s_axi_arvalid (s_axi_arvalid),
      .s_axi_arready (s_axi_arready),
      .s_axi_rdata   (s_axi_rdata),
      .s_axi_rresp   (s_axi_rresp),
      .s_axi_rvalid  (s_axi_rvalid),
      .s_axi_rready  (s_axi_rready),
      .wr_en         (wr_en),
      .wr_addr       (wr_addr),
      .wr_data       (wr_data),
      .wr_strb       (wr_strb),
      .wr_err        (wr_err),
      .rd_en         (rd_en),
      .rd_addr       (rd_addr),
      .rd_data       (rd_data),
      .rd_err        (rd_err)
   );

   logic        irq_en_q, done_q, cfg_start_q;
   logic [31:0] src_q, dst_q, size_q, xcount_q;

   logic       wr_in_range, ctrl_hit, start_req, start_allowed, start_ok;
   logic       cfg_hit, cfg_we, done_w1c;
   logic [2:0] wr_idx;

   assign wr_in_range   = wr_addr < ADDR_WIDTH'(REG_SPACE_BYTES);
   assign wr_idx        = wr_addr[4:2];
   // CTRL and STATUS only react when byte lane 0 is written.
   assign ctrl_hit      = wr_in_range && (wr_idx == IDX_CTRL) && wr_strb[0];
   assign start_req     = ctrl_hit && wr_data[CTRL_START_BIT];
   assign start_allowed = !status_busy && (size_q != '0);
   assign cfg_hit       = wr_in_range &&
                          ((wr_idx == IDX_SRC) || (wr_idx == IDX_DST) || (wr_idx == IDX_SIZE));
   // wr_err is only sampled by the front end on the commit cycle.
   assign wr_err        = !wr_in_range || (start_req && !start_allowed) ||
                          (cfg_hit && status_busy);
   assign start_ok      = wr_en && start_req && start_allowed;
   assign cfg_we        = wr_en && cfg_hit && !status_busy;
   assign done_w1c      = wr_en && wr_in_range && (wr_idx == IDX_STATUS) &&
                          wr_strb[0] && wr_data[STATUS_DONE_BIT];

   always_ff @(posedge clk) begin
      if (rst) begin
         irq_en_q    <= 1'b0;
         done_q      <= 1'b0;
         cfg_start_q <= 1'b0;
         src_q       <= '0;
         dst_q       <= '0;
         size_q      <= '0;
         xcount_q    <= '0;
      end else begin
         cfg_start_q <= start_ok;
         if (wr_en && ctrl_hit) irq_en_q <= wr_data[CTRL_IRQ_EN_BIT];
         if (cfg_we) begin
            case (wr_idx)
               IDX_SRC:  src_q  <= merge_strb(src_q,  wr_data, wr_strb);
               IDX_DST:  dst_q  <= merge_strb(dst_q,  wr_data, wr_strb);
               IDX_SIZE: size_q <= merge_strb(size_q, wr_data, wr_strb);
               default:  ;
            endcase
         end
         // A completion in the same cycle as a clear leaves DONE set.
         if (status_done)              done_q <= 1'b1;
         else if (start_ok || done_w1c) done_q <= 1'b0;
         if (status_done) xcount_q <= xcount_q + 32'd1;
      end
   end

   logic       rd_in_range;
   logic [2:0] rd_idx;

   assign rd_in_range = rd_addr < ADDR_WIDTH'(REG_SPACE_BYTES);
   assign rd_idx      = rd_addr[4:2];
   assign rd_err      = !rd_in_range;

   always_comb begin
      rd_data = '0;
      if (rd_in_range) begin
         case (rd_idx)
            IDX_CTRL: rd_data[CTRL_IRQ_EN_BIT] = irq_en_q;
            IDX_STATUS: begin
               rd_data[STATUS_BUSY_BIT] = status_busy;
               rd_data[STATUS_DONE_BIT] = done_q;
            end
            IDX_SRC:    rd_data = src_q;
            IDX_DST:    rd_data = dst_q;
            IDX_SIZE:   rd_data = size_q;
            IDX_XCOUNT: rd_data = xcount_q;
            default:    rd_data = '0;
         endcase
      end
   end

   assign cfg_src   = src_q;
   assign cfg_dst   = dst_q;
   assign cfg_size  = size_q;
   assign cfg_start = cfg_start_q;
   assign irq       = done_q && irq_en_q;

endmodule

// File: tb/tb_cgra_dma_csr.sv
module tb_cgra_dma_csr;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  s_axi_awaddr = '0;
   logic        s_axi_awvalid = 1'b0;
   logic        s_axi_awready;
   logic [31:0] s_axi_wdata = '0;
   logic [3:0]  s_axi_wstrb = '0;
   logic        s_axi_wvalid = 1'b0;
   logic        s_axi_wready;
   logic [1:0]  s_axi_bresp;
   logic        s_axi_bvalid;
   logic        s_axi_bready = 1'b0;
   logic [7:0]  s_axi_araddr = '0;
   logic        s_axi_arvalid = 1'b0;
   logic        s_axi_arready;
   logic [31:0] s_axi_rdata;
   logic [1:0]  s_axi_rresp;
   logic        s_axi_rvalid;
   logic        s_axi_rready = 1'b0;
   logic [31:0] cfg_src, cfg_dst, cfg_size;
   logic        cfg_start;
   logic        status_busy = 1'b0;
   logic        status_done = 1'b0;
   logic        irq;

   cgra_dma_csr #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) dut (
      .clk           (clk),
      .rst           (rst),
      .s_axi_awaddr  (s_axi_awaddr),
      .s_axi_awvalid (s_axi_awvalid),
      .s_axi_awready (s_axi_awready),
      .s_axi_wdata   (s_axi_wdata),
      .s_axi_wstrb   (s_axi_wstrb),
      .s_axi_wvalid  (s_axi_wvalid),
      .s_axi_wready  (s_axi_wready),
      .s_axi_bresp   (s_axi_bresp),
      .s_axi_bvalid  (s_axi_bvalid),
      .s_axi_bready  (s_axi_bready),
      .s_axi_araddr  (s_axi_araddr),
      .s_axi_arvalid (s_axi_arvalid),
      .s_axi_arready (s_axi_arready),
      .s_axi_rdata   (s_axi_rdata),
      .s_axi_rresp   (s_axi_rresp),
      .s_axi_rvalid  (s_axi_rvalid),
      .s_axi_rready  (s_axi_rready),
      .cfg_src       (cfg_src),
      .cfg_dst       (cfg_dst),
      .cfg_size      (cfg_size),
      .cfg_start     (cfg_start),
      .status_busy   (status_busy),
      .status_done   (status_done),
      .irq           (irq)
   );

   always #5 clk = ~clk;

   int total  = 0;
   int passed = 0;
   int failed = 0;
   int dut_starts = 0;

   // Every high cycle of cfg_start is one start pulse seen by the engine.
   always @(negedge clk) if (cfg_start) dut_starts++;

   // Reference model state: what the register file should hold.
   logic        m_irq_en = 1'b0;
   logic        m_done   = 1'b0;
   logic [31:0] m_cfg [0:2] = '{32'd0, 32'd0, 32'd0};
   logic [31:0] m_xcount = '0;
   int          m_starts = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic model_write(input logic [7:0] addr, input logic [31:0] data,
                              input logic [3:0] strb, input bit done_pulse,
                              output logic [1:0] resp);
      bit err = 0, start = 0, w1c = 0;
      int idx = int'(addr) / 4;
      if (addr >= 8'h18) err = 1;
      else if (idx == 0) begin
         if (strb[0]) begin
            m_irq_en = data[1];
            if (data[0]) begin
               if (status_busy || m_cfg[2] == 0) err = 1;
               else begin start = 1; m_starts++; end
            end
         end
      end else if (idx == 1) begin
         if (strb[0] && data[1]) w1c = 1;
      end else if (idx >= 2 && idx <= 4) begin
         if (status_busy) err = 1;
         else for (int b = 0; b < 4; b++)
            if (strb[b]) m_cfg[idx-2][8*b +: 8] = data[8*b +: 8];
      end
      if (done_pulse) begin
         m_done = 1'b1;
         m_xcount++;
      end else if (start || w1c) m_done = 1'b0;
      resp = err ? 2'b10 : 2'b00;
   endtask

   function automatic logic [31:0] model_read(input logic [7:0] addr);
      int idx = int'(addr) / 4;
      if (addr >= 8'h18) return 32'd0;
      case (idx)
         0: return {30'd0, m_irq_en, 1'b0};
         1: return {30'd0, m_done, status_busy};
         2, 3, 4: return m_cfg[idx-2];
         default: return m_xcount;
      endcase
   endfunction

   // W leads AW by w_lead cycles; bready stays low for b_hold cycles of bvalid.
   // done_on_commit raises status_done exactly in the commit cycle.
   task automatic axi_write(input logic [7:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input int w_lead, input int b_hold,
                            input bit done_on_commit, output logic [1:0] resp);
      bit aw_ok = 0, w_ok = 0, hs_aw, hs_w;
      int n = 0;
      resp = 2'bxx;
      @(negedge clk);
      s_axi_awaddr = addr;
      s_axi_wdata  = data;
      s_axi_wstrb  = strb;
      while (!(aw_ok && w_ok) && n < 100) begin
         s_axi_wvalid  = !w_ok;
         s_axi_awvalid = !aw_ok && (n >= w_lead);
         #1;
         hs_aw = s_axi_awvalid && s_axi_awready;
         hs_w  = s_axi_wvalid && s_axi_wready;
         @(posedge clk);
         if (hs_aw) aw_ok = 1;
         if (hs_w)  w_ok = 1;
         @(negedge clk);
         s_axi_awvalid = 1'b0;
         s_axi_wvalid  = 1'b0;
         n++;
      end
      check("aw_w_accepted", {31'd0, aw_ok && w_ok}, 32'd1);
      if (done_on_commit) begin
         status_done = 1'b1;
         @(negedge clk);
         status_done = 1'b0;
      end
      n = 0;
      while (!s_axi_bvalid && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("bvalid_seen", {31'd0, s_axi_bvalid}, 32'd1);
      for (int i = 0; i < b_hold; i++) begin
         @(negedge clk);
         check("bvalid_held", {31'd0, s_axi_bvalid}, 32'd1);
      end
      s_axi_bready = 1'b1;
      resp = s_axi_bresp;
      @(posedge clk);
      @(negedge clk);
      s_axi_bready = 1'b0;
   endtask

   task automatic axi_read(input logic [7:0] addr, output logic [31:0] data,
                           output logic [1:0] resp);
      bit hs = 0;
      int n = 0;
      data = 'x;
      resp = 'x;
      @(negedge clk);
      s_axi_araddr  = addr;
      s_axi_arvalid = 1'b1;
      while (!hs && n < 20) begin
         #1;
         hs = s_axi_arready;
         @(posedge clk);
         @(negedge clk);
         n++;
      end
      s_axi_arvalid = 1'b0;
      check("ar_accepted", {31'd0, hs}, 32'd1);
      n = 0;
      while (!s_axi_rvalid && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("rvalid_seen", {31'd0, s_axi_rvalid}, 32'd1);
      s_axi_rready = 1'b1;
      data = s_axi_rdata;
      resp = s_axi_rresp;
      @(posedge clk);
      @(negedge clk);
      s_axi_rready = 1'b0;
   endtask

   task automatic do_write(input logic [7:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int w_lead, input int b_hold,
                           input bit done_on_commit);
      logic [1:0] exp_resp, got_resp;
      model_write(addr, data, strb, done_on_commit, exp_resp);
      axi_write(addr, data, strb, w_lead, b_hold, done_on_commit, got_resp);
      check("bresp", {30'd0, got_resp}, {30'd0, exp_resp});
      check("start_pulses", dut_starts, m_starts);
      check("cfg_src", cfg_src, m_cfg[0]);
      check("cfg_dst", cfg_dst, m_cfg[1]);
      check("cfg_size", cfg_size, m_cfg[2]);
      check("irq", {31'd0, irq}, {31'd0, m_done & m_irq_en});
   endtask

   task automatic do_read(input logic [7:0] addr);
      logic [31:0] d;
      logic [1:0]  r;
      axi_read(addr, d, r);
      check($sformatf("rdata@%02h", addr), d, model_read(addr));
      check($sformatf("rresp@%02h", addr), {30'd0, r}, (addr >= 8'h18) ? 32'd2 : 32'd0);
   endtask

   task automatic pulse_done();
      @(negedge clk);
      status_done = 1'b1;
      @(negedge clk);
      status_done = 1'b0;
      m_done = 1'b1;
      m_xcount++;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0]  a;
      logic [31:0] d;
      logic [3:0]  s;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_awready", {31'd0, s_axi_awready}, 32'd0);
      check("rst_wready",  {31'd0, s_axi_wready},  32'd0);
      check("rst_arready", {31'd0, s_axi_arready}, 32'd0);
      check("rst_bvalid",  {31'd0, s_axi_bvalid},  32'd0);
      check("rst_rvalid",  {31'd0, s_axi_rvalid},  32'd0);
      check("rst_cfg_start", {31'd0, cfg_start}, 32'd0);
      check("rst_irq", {31'd0, irq}, 32'd0);
      rst = 1'b0;
      for (int i = 0; i < 6; i++) do_read(8'(4 * i));

      // Program and start a transfer
      do_write(8'h08, 32'h0000_1000, 4'hF, 0, 0, 0);
      do_write(8'h0C, 32'h0000_2000, 4'hF, 1, 0, 0);
      do_write(8'h10, 32'h0000_0010, 4'hF, 0, 1, 0);
      do_write(8'h00, 32'h0000_0003, 4'hF, 0, 0, 0);
      check("cfg_src_direct", cfg_src, 32'h0000_1000);
      check("start_once", dut_starts, 1);

      // Completion, DONE/XCOUNT/irq, then W1C
      pulse_done();
      check("irq_after_done", {31'd0, irq}, 32'd1);
      do_read(8'h04);
      do_read(8'h14);
      do_write(8'h04, 32'h0000_0002, 4'hF, 0, 0, 0);
      check("irq_after_w1c", {31'd0, irq}, 32'd0);

      // Engine busy: config writes and START rejected
      status_busy = 1'b1;
      do_write(8'h08, 32'h0000_DEAD, 4'hF, 0, 0, 0);
      do_write(8'h00, 32'h0000_0001, 4'hF, 0, 0, 0);
      do_read(8'h04);
      status_busy = 1'b0;

      // SIZE==0 start and out-of-range read
      do_write(8'h10, 32'h0000_0000, 4'hF, 0, 0, 0);
      do_write(8'h00, 32'h0000_0001, 4'hF, 0, 0, 0);
      do_read(8'h20);

      // Back-pressure: W three cycles ahead of AW, bready held low four cycles
      do_write(8'h08, 32'h0000_3000, 4'hF, 3, 4, 0);
      do_read(8'h08);
      // W1C landing on the same cycle as a completion: DONE stays set
      do_write(8'h04, 32'h0000_0002, 4'hF, 0, 0, 1);
      do_read(8'h04);
      do_read(8'h14);

      // Randomized traffic against the model
      for (int it = 0; it < 50; it++) begin
         status_busy = ($urandom_range(0, 3) == 0);
         a = 8'(4 * $urandom_range(0, 8));
         d = $urandom;
         if ($urandom_range(0, 3) == 0) d = {28'd0, d[3:0]};
         s = ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom_range(0, 15));
         if ($urandom_range(0, 5) == 0) pulse_done();
         do_write(a, d, s, $urandom_range(0, 2), $urandom_range(0, 2),
                  ($urandom_range(0, 7) == 0));
         do_read(8'(4 * $urandom_range(0, 7)));
      end
      status_busy = 1'b0;
      for (int i = 0; i < 6; i++) do_read(8'(4 * i));

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
